fmac_fifo_rd_framer: RTL and testbench

- Read-side consumer of the 4Kx32 MAC packet FIFO, running in the FIFO read-clock domain.
- Pops length-prefixed packets from the FIFO read port and re-frames them onto a valid/ready word stream with sop/eop/byte-enables.
- Feeds the downstream MAC TX/RX datapath.
- Absorbs the FIFO's one-cycle read latency and downstream backpressure with a small skid buffer.

---
 rtl/fmac_fifo_rd_framer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_fmac_fifo_rd_framer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmac_fifo_rd_framer.sv
`default_nettype none
// ============================================================================
// Module      : fmac_fifo_rd_framer
// Description : Read-side framer for the 4Kx32 MAC packet FIFO. Pops
//               length-prefixed packets, absorbs the FIFO read latency and
//               downstream backpressure with a small skid buffer, and emits
//               a valid/ready word stream with sop/eop/byte-enables.
//               Optional statistics outputs: define FMAC_RDFRAMER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fmac_fifo_rd_framer #(
  parameter int WIDTH   = 32,
  parameter int PTR     = 12,
  parameter int MAX_LEN = 1518,
  parameter int SKID    = 4
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             fifo_rdempty,
  input  logic [PTR:0]     fifo_rdusedw,
  output logic             fifo_rdreq,
  input  logic [WIDTH-1:0] fifo_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic [3:0]       out_be,
  output logic             pkt_err
`ifdef FMAC_RDFRAMER_STATS_EN
  ,
  output logic [31:0]      pkt_cnt,
  output logic [15:0]      drop_cnt,
  output logic [PTR:0]     max_used
`endif
);

  localparam int SPW  = $clog2(SKID);
  localparam int OCCW = SPW + 1;
  localparam int SUMW = OCCW + 1;
  localparam int ENTW = WIDTH + 6;
  localparam int TAGW = 8;

  localparam logic [15:0]     MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [SUMW-1:0] SKID_W    = SUMW'(SKID);

  // Request tag kinds: {kind[1:0], sop, eop, be[3:0]}
  localparam logic [1:0] TAG_HDR  = 2'd1;
  localparam logic [1:0] TAG_DATA = 2'd2;
  localparam logic [1:0] TAG_DROP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t            state, state_n;
  logic              active;
  logic [15:0]       rem, rem_n;
  logic              first, first_n;
  logic [3:0]        be_last, be_n;
  logic              err_n;

  logic [TAGW-1:0]   tag_mem [2];
  logic              tag_wp, tag_rp;
  logic [1:0]        tag_cnt;
  logic              ret;
  logic [TAGW-1:0]   ret_tag, req_tag;
  logic              ret_hdr;

  logic [ENTW-1:0]   skid_mem [SKID];
  logic [SPW-1:0]    skid_wp, skid_rp;
  logic [OCCW-1:0]   occ;
  logic              push, pop;

  logic [15:0]       hdr_len, hdr_wc;
  logic [3:0]        hdr_be;
  logic              hdr_drop;
  logic              space, can_req;
  logic [1:0]        data_kind;

  // Returned word is identified by the tag of the oldest outstanding request
  assign ret_tag   = tag_mem[tag_rp];
  assign ret_hdr   = ret & (ret_tag[7:6] == TAG_HDR);
  assign push      = ret & (ret_tag[7:6] == TAG_DATA);

  assign hdr_len   = fifo_q[15:0];
  assign hdr_wc    = 16'((17'(hdr_len) + 17'd3) >> 2);
  assign hdr_drop  = hdr_len > MAX_LEN_W;

  // Requests in flight are counted so the skid buffer can never overflow
  assign space     = (SUMW'(occ) + SUMW'(tag_cnt)) < SKID_W;
  assign can_req   = active & ~fifo_rdempty & space;

  assign out_valid = occ != '0;
  assign pop       = out_valid & out_ready;
  assign {out_sop, out_eop, out_be, out_data} = skid_mem[skid_rp];
  assign data_kind = (state == S_DROP) ? TAG_DROP : TAG_DATA;

  // Byte enables of the final word from the residual byte count
  always_comb begin
    hdr_be = 4'hF;
    case (hdr_len[1:0])
      2'd1:    hdr_be = 4'h1;
      2'd2:    hdr_be = 4'h3;
      2'd3:    hdr_be = 4'h7;
      default: hdr_be = 4'hF;
    endcase
  end

  // Next-state, read request and request tag generation
  always_comb begin
    state_n    = state;
    fifo_rdreq = 1'b0;
    req_tag    = '0;
    rem_n      = rem;
    first_n    = first;
    be_n       = be_last;
    err_n      = 1'b0;
    case (state)
      S_IDLE: begin
        if (can_req) begin
          fifo_rdreq = 1'b1;
          req_tag    = {TAG_HDR, 6'd0};
          state_n    = S_HDR;
        end
      end
      S_HDR: begin
        if (ret_hdr) begin
          be_n = hdr_be;
          if (hdr_len == 16'd0) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end else begin
            err_n = hdr_drop;
            // First data request goes out in the same cycle the header lands
            if (can_req) begin
              fifo_rdreq = 1'b1;
              req_tag    = {(hdr_drop ? TAG_DROP : TAG_DATA), 1'b1,
                            (hdr_wc == 16'd1),
                            ((hdr_wc == 16'd1) ? hdr_be : 4'hF)};
              rem_n      = hdr_wc - 16'd1;
              first_n    = 1'b0;
              state_n    = (hdr_wc == 16'd1) ? S_IDLE :
                           (hdr_drop ? S_DROP : S_DATA);
            end else begin
              rem_n   = hdr_wc;
              first_n = 1'b1;
              state_n = hdr_drop ? S_DROP : S_DATA;
            end
          end
        end
      end
      S_DATA, S_DROP: begin
        if (can_req) begin
          fifo_rdreq = 1'b1;
          req_tag    = {data_kind, first, (rem == 16'd1),
                        ((rem == 16'd1) ? be_last : 4'hF)};
          rem_n      = rem - 16'd1;
          first_n    = 1'b0;
          if (rem == 16'd1) begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register, packet context and error pulse; active gates requests in reset
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state   <= S_IDLE;
      active  <= 1'b0;
      rem     <= '0;
      first   <= 1'b0;
      be_last <= '0;
      pkt_err <= 1'b0;
    end else begin
      state   <= state_n;
      active  <= 1'b1;
      rem     <= rem_n;
      first   <= first_n;
      be_last <= be_n;
      pkt_err <= err_n;
    end
  end

  // Two-entry tag FIFO tracking requests whose data has not yet returned
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      tag_mem[0] <= '0;
      tag_mem[1] <= '0;
      tag_wp     <= 1'b0;
      tag_rp     <= 1'b0;
      tag_cnt    <= '0;
      ret        <= 1'b0;
    end else begin
      ret <= fifo_rdreq;
      if (fifo_rdreq) begin
        tag_mem[tag_wp] <= req_tag;
        tag_wp          <= ~tag_wp;
      end
      if (ret) begin
        tag_rp <= ~tag_rp;
      end
      case ({fifo_rdreq, ret})
        2'b10:   tag_cnt <= tag_cnt + 2'd1;
        2'b01:   tag_cnt <= tag_cnt - 2'd1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // Skid buffer: data words with their sop/eop/be tags, popped by downstream
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < SKID; i++) begin
        skid_mem[i] <= '0;
      end
      skid_wp <= '0;
      skid_rp <= '0;
      occ     <= '0;
    end else begin
      if (push) begin
        skid_mem[skid_wp] <= {ret_tag[5:0], fifo_q};
        skid_wp           <= skid_wp + 1'b1;
      end
      if (pop) begin
        skid_rp <= skid_rp + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef FMAC_RDFRAMER_STATS_EN
  // Packet, drop and FIFO high-water statistics
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      max_used <= '0;
    end else begin
      if (pop & out_eop) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end
      if (err_n && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (fifo_rdusedw > max_used) begin
        max_used <= fifo_rdusedw;
      end
    end
  end
`else
  logic unused_rdusedw;
  assign unused_rdusedw = ^fifo_rdusedw;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fmac_fifo_rd_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmac_fifo_rd_framer
// Description : Directed self-checking bench for fmac_fifo_rd_framer with a
//               packet-level scoreboard and an occupancy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmac_fifo_rd_framer;

  localparam int WIDTH   = 32;
  localparam int PTR     = 12;
  localparam int MAX_LEN = 1518;
  localparam int SKID    = 4;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        e;
    logic [3:0]  be;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset_;
  logic              fifo_rdempty;
  logic [PTR:0]      fifo_rdusedw;
  logic              fifo_rdreq;
  logic [WIDTH-1:0]  fifo_q = '0;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_sop;
  logic              out_eop;
  logic [3:0]        out_be;
  logic              pkt_err;
`ifdef FMAC_RDFRAMER_STATS_EN
  logic [31:0]       pkt_cnt;
  logic [15:0]       drop_cnt;
  logic [PTR:0]      max_used;
`endif

  always #5 clk = ~clk;

  fmac_fifo_rd_framer #(
    .WIDTH(WIDTH), .PTR(PTR), .MAX_LEN(MAX_LEN), .SKID(SKID)
  ) dut (
    .clk(clk),
    .reset_(reset_),
    .fifo_rdempty(fifo_rdempty),
    .fifo_rdusedw(fifo_rdusedw),
    .fifo_rdreq(fifo_rdreq),
    .fifo_q(fifo_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sop(out_sop),
    .out_eop(out_eop),
    .out_be(out_be),
    .pkt_err(pkt_err)
`ifdef FMAC_RDFRAMER_STATS_EN
    ,
    .pkt_cnt(pkt_cnt),
    .drop_cnt(drop_cnt),
    .max_used(max_used)
`endif
  );

  // FIFO model: words with a flag telling whether each one is deliverable data
  logic [31:0] fmem [0:4095];
  bit          fdat [0:4095];
  int          wr_idx = 0;
  int          rd_idx = 0;
  int          stage_idx = 0;
  bit          force_empty = 1'b0;
  bit          flush = 1'b0;

  assign fifo_rdempty = (rd_idx == wr_idx) || force_empty;
  assign fifo_rdusedw = 13'(wr_idx - rd_idx);

  always @(posedge clk) begin
    if (flush) begin
      rd_idx <= wr_idx;
    end else if (fifo_rdreq && (rd_idx < wr_idx)) begin
      fifo_q <= fmem[rd_idx];
      rd_idx <= rd_idx + 1;
    end
  end

  // Scoreboard and model state
  beat_t expq [$];
  beat_t obs  [$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    exp_err = 0;
  int    seen_err = 0;
  int    est_occ = 0;
  bit    prev_ret_data = 1'b0;
  bit    stall_prev = 1'b0;
  beat_t prev_out;
  bit    ready_toggle = 1'b0;
  int    empty_cnt = 0;
  bit    tp_mode = 1'b0;
  int    sop_cyc = 0;
  int    span_cnt = 0;
  int    cyc = 0;
  int    last_wc = 0;

  function automatic beat_t mk(input logic [31:0] d, input logic s,
                               input logic e, input logic [3:0] be);
    beat_t b;
    b.d = d; b.s = s; b.e = e; b.be = be;
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Build one packet into the FIFO image and the expected beat stream
  task automatic stage(input int len, input logic [31:0] base);
    int    wc;
    int    r;
    beat_t b;
    fmem[stage_idx] = {16'h5A5A, 16'(len)};
    fdat[stage_idx] = 1'b0;
    stage_idx++;
    wc = (len + 3) / 4;
    last_wc = wc;
    if (len == 0 || len > MAX_LEN) exp_err++;
    for (int i = 0; i < wc; i++) begin
      fmem[stage_idx] = base + 32'(i);
      fdat[stage_idx] = (len <= MAX_LEN);
      stage_idx++;
      if (len <= MAX_LEN) begin
        r    = len % 4;
        b.d  = base + 32'(i);
        b.s  = (i == 0);
        b.e  = (i == wc - 1);
        b.be = (i == wc - 1 && r != 0) ? 4'((1 << r) - 1) : 4'hF;
        expq.push_back(b);
      end
    end
  endtask

  task automatic commit();
    wr_idx = stage_idx;
  endtask

  // Per-cycle compare against the scoreboard and occupancy model
  task automatic compare_cycle();
    beat_t cur;
    beat_t e;
    bit    popping;
    cur = mk(out_data, out_sop, out_eop, out_be);
    popping = out_valid && out_ready;
    if (fifo_rdreq) check("rdreq_while_empty", 64'(fifo_rdempty), 64'(0));
    check("out_valid_vs_occ", 64'(out_valid), 64'(est_occ != 0));
    check("occ_bound", 64'(est_occ > SKID), 64'(0));
    if (stall_prev) check("hold_stable", 64'(cur), 64'(prev_out));
    if (pkt_err) seen_err++;
    if (popping) begin
      if (expq.size() == 0) begin
        check("unexpected_beat", 64'(cur), 64'(0));
      end else begin
        e = expq.pop_front();
        check("beat", 64'(cur), 64'(e));
      end
      obs.push_back(cur);
      if (out_sop) sop_cyc = cyc;
      if (out_eop && tp_mode) begin
        check("pkt_span_cycles", 64'(cyc - sop_cyc + 1), 64'(375));
        span_cnt++;
      end
    end
    stall_prev = out_valid && !out_ready;
    prev_out   = cur;
    est_occ    = est_occ + int'(prev_ret_data) - int'(popping);
    prev_ret_data = fifo_rdreq && fdat[rd_idx];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    out_ready = ready_toggle ? ~out_ready : 1'b1;
    force_empty = (empty_cnt > 0);
    if (empty_cnt > 0) empty_cnt--;
    @(negedge clk);
    compare_cycle();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!(expq.size() == 0 && rd_idx == wr_idx && est_occ == 0 && !out_valid)
           && n < budget) begin
      tick();
      n++;
    end
    check("drain_beats_left", 64'(expq.size()), 64'(0));
    check("drain_fifo_left", 64'(wr_idx - rd_idx), 64'(0));
    repeat (4) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdreq"}, 64'(fifo_rdreq), 64'(0));
    check({tag, "_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_sop"},   64'(out_sop),   64'(0));
    check({tag, "_eop"},   64'(out_eop),   64'(0));
    check({tag, "_be"},    64'(out_be),    64'(0));
    check({tag, "_data"},  64'(out_data),  64'(0));
    check({tag, "_err"},   64'(pkt_err),   64'(0));
  endtask

  task automatic new_test();
    exp_err  = 0;
    seen_err = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    reset_    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 reset_ = 1'b1;
    @(negedge clk);

    // LEN=8: two full words
    new_test();
    b0 = obs.size();
    stage(8, 32'hA000_0000);
    commit();
    drain(200);
    check("t1_beats", 64'(obs.size() - b0), 64'(2));
    check("t1_w0", 64'(obs[b0]),     64'(mk(32'hA000_0000, 1'b1, 1'b0, 4'hF)));
    check("t1_w1", 64'(obs[b0 + 1]), 64'(mk(32'hA000_0001, 1'b0, 1'b1, 4'hF)));
    check("t1_err", 64'(seen_err), 64'(0));

    // LEN=5 then LEN=1: partial last words
    new_test();
    b0 = obs.size();
    stage(5, 32'hC000_0000);
    stage(1, 32'hD000_0000);
    commit();
    drain(200);
    check("t2_beats", 64'(obs.size() - b0), 64'(3));
    check("t2_len5_last", 64'(obs[b0 + 1]), 64'(mk(32'hC000_0001, 1'b0, 1'b1, 4'h1)));
    check("t2_len1", 64'(obs[b0 + 2]), 64'(mk(32'hD000_0000, 1'b1, 1'b1, 4'h1)));
    check("t2_err", 64'(seen_err), 64'(exp_err));

    // LEN=0 header then LEN=4
    new_test();
    b0 = obs.size();
    stage(0, 32'h0);
    stage(4, 32'hE000_0000);
    commit();
    drain(200);
    check("t3_err", 64'(seen_err), 64'(1));
    check("t3_beats", 64'(obs.size() - b0), 64'(1));
    check("t3_w0", 64'(obs[b0]), 64'(mk(32'hE000_0000, 1'b1, 1'b1, 4'hF)));

    // LEN=2000 dropped, then LEN=4
    new_test();
    b0 = obs.size();
    stage(2000, 32'hF000_0000);
    check("t4_model_wc", 64'(last_wc), 64'(500));
    stage(4, 32'hF100_0000);
    commit();
    drain(2000);
    check("t4_err", 64'(seen_err), 64'(1));
    check("t4_beats", 64'(obs.size() - b0), 64'(1));
    check("t4_w0", 64'(obs[b0]), 64'(mk(32'hF100_0000, 1'b1, 1'b1, 4'hF)));

    // 64 bytes with toggling ready and a 3-cycle underrun
    new_test();
    b0 = obs.size();
    ready_toggle = 1'b1;
    stage(64, 32'h5000_0000);
    commit();
    repeat (6) tick();
    empty_cnt = 3;
    drain(500);
    ready_toggle = 1'b0;
    tick();
    check("t5_beats", 64'(obs.size() - b0), 64'(16));
    check("t5_last", 64'(obs[b0 + 15]), 64'(mk(32'h5000_000F, 1'b0, 1'b1, 4'hF)));
    check("t5_err", 64'(seen_err), 64'(0));

    // Back-to-back 1500-byte packets at full rate
    new_test();
    b0 = obs.size();
    tp_mode = 1'b1;
    span_cnt = 0;
    stage(1500, 32'h6000_0000);
    stage(1500, 32'h6100_0000);
    commit();
    drain(2000);
    tp_mode = 1'b0;
    check("t6_beats", 64'(obs.size() - b0), 64'(750));
    check("t6_spans", 64'(span_cnt), 64'(2));

    // Reset mid-packet
    new_test();
    stage(1500, 32'h7000_0000);
    commit();
    repeat (100) tick();
    @(posedge clk);
    #2;
    reset_ = 1'b0;
    flush  = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    @(negedge clk);
    check("midreset_state_idle", 64'(dut.state), 64'(0));
    expq.delete();
    est_occ = 0;
    prev_ret_data = 1'b0;
    stall_prev = 1'b0;
    @(posedge clk);
    #1;
    reset_ = 1'b1;
    flush  = 1'b0;
    @(negedge clk);

    // Recovery packet after reset
    new_test();
    b0 = obs.size();
    stage(12, 32'h8000_0000);
    commit();
    drain(200);
    check("t7_beats", 64'(obs.size() - b0), 64'(3));
    check("t7_w0", 64'(obs[b0]), 64'(mk(32'h8000_0000, 1'b1, 1'b0, 4'hF)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
